// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 3-bit-opcode CPU: fetch/decode/execute/memory/writeback
// sequencing with a req/ready memory handshake, halt/resume and a saturating retire counter.
module multicycle_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src,
   output logic [2:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             busy,
   output logic             halted,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXEC    = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_HALT    = 3'd6,
      S_ILLEGAL = 3'd7
   } state_t;

   localparam logic [2:0] OP_ALU_A  = 3'd0;
   localparam logic [2:0] OP_ALU_I  = 3'd1;
   localparam logic [2:0] OP_LOAD   = 3'd2;
   localparam logic [2:0] OP_STORE  = 3'd3;
   localparam logic [2:0] OP_BRANCH = 3'd4;
   localparam logic [2:0] OP_JAL    = 3'd5;
   localparam logic [2:0] OP_JALR   = 3'd6;
   localparam logic [2:0] OP_HALT   = 3'd7;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= 3'd0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      alu_src   = 1'b0;
      alu_op    = 3'd0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (opcode == OP_HALT) begin
               retire  = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_op  = op_q;
            alu_src = (op_q != OP_ALU_A);
            case (op_q)
               OP_ALU_A, OP_ALU_I: state_d = S_WB;
               OP_LOAD, OP_STORE:  state_d = S_MEM;
               OP_BRANCH: begin
                  pc_src   = 2'd1;
                  pc_write = alu_zero;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_JAL, OP_JALR: begin
                  pc_src    = (op_q == OP_JAL) ? 2'd2 : 2'd3;
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
                  wb_sel    = 2'd2;
                  retire    = 1'b1;
                  state_d   = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            // ALU controls held so the address computed in EXEC stays on the bus
            mem_req = 1'b1;
            mem_we  = (op_q == OP_STORE);
            alu_op  = op_q;
            alu_src = (op_q != OP_ALU_A);
            if (mem_ready) begin
               if (op_q == OP_STORE) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = (op_q == OP_LOAD) ? 2'd1 : 2'd0;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_HALT: begin
            if (start) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      retired_d = (retire && (retired_q != CNT_MAX)) ? retired_q + CNT_ONE : retired_q;
   end

   assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted  = (state_q == S_HALT);
   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: an instruction-level model walks each
// instruction's phases and predicts strobes, state and retire counts cycle by cycle.
module tb_multicycle_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  opcode;
   logic        alu_zero;
   logic        mem_ready;

   logic        mem_req, mem_we, ir_write, pc_write, alu_src, reg_write, busy, halted;
   logic [1:0]  pc_src, wb_sel;
   logic [2:0]  alu_op, state;
   logic [15:0] retired;

   logic        mem_req2, mem_we2, ir_write2, pc_write2, alu_src2, reg_write2, busy2, halted2;
   logic [1:0]  pc_src2, wb_sel2;
   logic [2:0]  alu_op2, state2;
   logic [1:0]  retired2;

   logic [17:0] outs, outs2;

   int tests_run = 0;
   int tests_failed = 0;
   int rcount = 0;

   multicycle_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
      .reg_write(reg_write), .wb_sel(wb_sel), .busy(busy), .halted(halted),
      .state(state), .retired(retired)
   );

   multicycle_sequencer #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .mem_req(mem_req2), .mem_we(mem_we2), .ir_write(ir_write2),
      .pc_write(pc_write2), .pc_src(pc_src2), .alu_src(alu_src2), .alu_op(alu_op2),
      .reg_write(reg_write2), .wb_sel(wb_sel2), .busy(busy2), .halted(halted2),
      .state(state2), .retired(retired2)
   );

   assign outs  = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
                   reg_write, wb_sel, busy, halted, state};
   assign outs2 = {mem_req2, mem_we2, ir_write2, pc_write2, pc_src2, alu_src2, alu_op2,
                   reg_write2, wb_sel2, busy2, halted2, state2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] pk(input logic [2:0] st, input logic req, input logic we,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic asrc, input logic [2:0] aop, input logic regw,
                                      input logic [1:0] wbs);
      logic bsy, hlt;
      bsy = (st != 3'd0) && (st != 3'd6);
      hlt = (st == 3'd6);
      return {req, we, irw, pcw, pcs, asrc, aop, regw, wbs, bsy, hlt, st};
   endfunction

   // Noise on inputs the current phase must ignore.
   task automatic jitter();
      opcode    = 3'($urandom_range(0, 7));
      alu_zero  = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
   endtask

   task automatic cyc(input string tag, input logic [17:0] exp);
      @(negedge clk);
      check_eq(tag, 32'(outs), 32'(exp));
      check_eq({tag, "_ret"}, 32'(retired), 32'(rcount));
      check_eq({tag, "_w2"}, 32'(outs2), 32'(exp));
      check_eq({tag, "_ret2"}, 32'(retired2), 32'((rcount > 3) ? 3 : rcount));
      @(posedge clk);
      #1;
   endtask

   task automatic go_from_idle(input int wait_cycles);
      for (int i = 0; i <= wait_cycles; i++) begin
         jitter();
         start = (i == wait_cycles);
         cyc("idle", pk(3'd0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 2'd0));
      end
   endtask

   // One instruction from FETCH until the next FETCH (or IDLE after a reset in MEM).
   task automatic do_instr(input logic [2:0] op, input int fw, input int mw, input int hw,
                           input int zsel, input bit rst_in_mem);
      logic rdy, z, src;
      for (int i = 0; i <= fw; i++) begin
         jitter();
         rdy = (i == fw);
         mem_ready = rdy;
         cyc("fetch", pk(3'd1, 1, 0, rdy, rdy, 2'd0, 0, 3'd0, 0, 2'd0));
      end
      jitter();
      opcode = op;
      cyc("decode", pk(3'd2, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 2'd0));
      if (op == 3'd7) begin
         rcount++;
         for (int i = 0; i <= hw; i++) begin
            jitter();
            start = (i == hw);
            cyc("halt", pk(3'd6, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 2'd0));
         end
         return;
      end
      jitter();
      z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      alu_zero = z;
      src = (op != 3'd0);
      case (op)
         3'd4: begin
            cyc("exec_br", pk(3'd3, 0, 0, 0, z, 2'd1, src, op, 0, 2'd0));
            rcount++;
            return;
         end
         3'd5: begin
            cyc("exec_jal", pk(3'd3, 0, 0, 0, 1, 2'd2, src, op, 1, 2'd2));
            rcount++;
            return;
         end
         3'd6: begin
            cyc("exec_jalr", pk(3'd3, 0, 0, 0, 1, 2'd3, src, op, 1, 2'd2));
            rcount++;
            return;
         end
         default: cyc("exec", pk(3'd3, 0, 0, 0, 0, 2'd0, src, op, 0, 2'd0));
      endcase
      if (op == 3'd2 || op == 3'd3) begin
         if (rst_in_mem) begin
            jitter();
            mem_ready = 1'b0;
            reset = 1'b1;
            cyc("mem_rst", pk(3'd4, 1, op == 3'd3, 0, 0, 2'd0, 1, op, 0, 2'd0));
            reset = 1'b0;
            rcount = 0;
            jitter();
            start = 1'b0;
            cyc("post_rst", pk(3'd0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 2'd0));
            return;
         end
         for (int i = 0; i <= mw; i++) begin
            jitter();
            mem_ready = (i == mw);
            cyc("mem", pk(3'd4, 1, op == 3'd3, 0, 0, 2'd0, 1, op, 0, 2'd0));
         end
         if (op == 3'd3) begin
            rcount++;
            return;
         end
      end
      jitter();
      cyc("wb", pk(3'd5, 0, 0, 0, 0, 2'd0, 0, 3'd0, 1, (op == 3'd2) ? 2'd1 : 2'd0));
      rcount++;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      opcode = 3'd0;
      alu_zero = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rcount = 0;
      cyc("reset", pk(3'd0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 2'd0));
      reset = 1'b0;

      go_from_idle(2);
      do_instr(3'd0, 0, 0, 0, -1, 1'b0);
      do_instr(3'd2, 0, 3, 0, -1, 1'b0);
      do_instr(3'd4, 0, 0, 0, 0, 1'b0);
      do_instr(3'd4, 0, 0, 0, 1, 1'b0);
      do_instr(3'd6, 1, 0, 0, -1, 1'b0);
      do_instr(3'd7, 0, 0, 2, -1, 1'b0);
      do_instr(3'd5, 2, 0, 0, -1, 1'b0);
      do_instr(3'd3, 0, 2, 0, -1, 1'b0);
      do_instr(3'd3, 0, 0, 0, -1, 1'b1);
      go_from_idle(1);

      for (int n = 0; n < 250; n++) begin
         do_instr(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the 3-bit-opcode CPU. It steps each instruction through fetch, decode, execute, memory and writeback, and drives per-state strobes to the PC, IR, ALU, register file and a shared single-port memory. Memory accesses use a req/ready handshake, so the memory may take any number of cycles to respond. It also keeps a retired-instruction counter and supports halt and resume.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high
start  in  1  level; leaves IDLE or HALT and begins fetching
opcode  in  3  IR[opcode]; valid from DECODE onward. 0 ALU_A, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 HALT
alu_zero  in  1  ALU zero flag; the branch condition, sampled in EXEC
mem_ready  in  1  memory completion; ignored unless mem_req=1
mem_req  out  1  memory access request
mem_we  out  1  1=write, 0=read; valid while mem_req=1
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  2  0 PC+1, 1 branch target, 2 jump target, 3 ALU result
alu_src  out  1  0 register operand B, 1 sign-extended immediate
alu_op  out  3  ALU operation (latched opcode)
reg_write  out  1  register-file write enable
wb_sel  out  2  0 ALU result, 1 memory data, 2 PC (link)
busy  out  1  1 in every state except IDLE and HALT
halted  out  1  1 in HALT
state  out  3  current state encoding, for debug
retired  out  CNT_W  number of instructions retired

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and goes to IDLE.
- Reset (synchronous) sets state=IDLE, op_q=0 and retired=0. Every output is 0 while in IDLE, including during the reset cycle. A reset in any state, including mid-handshake, takes effect at that edge; mem_req is 0 in the following cycle.
- Outputs are combinational from (state, op_q, alu_zero, mem_ready). Any strobe not listed for a state is 0.
- IDLE: start=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_we=0 every cycle; stay until mem_ready.
  - In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
- DECODE: op_q <= opcode. If opcode=7: retired increments, -> HALT. Otherwise -> EXEC.
- EXEC: alu_op=op_q; alu_src=0 if op_q=ALU_A, else 1.
  - ALU_A, ALU_I -> WB.
  - LOAD, STORE -> MEM.
  - BRANCH: pc_src=1, pc_write=alu_zero; retire; -> FETCH.
  - JAL: pc_src=2, pc_write=1, reg_write=1, wb_sel=2; retire; -> FETCH.
  - JALR: pc_src=3, pc_write=1, reg_write=1, wb_sel=2; retire; -> FETCH.
- MEM:
  - mem_req=1; mem_we=1 for STORE, 0 for LOAD. alu_op and alu_src are held as in EXEC so the address stays stable.
  - Stay until mem_ready. Then LOAD -> WB; STORE retires -> FETCH.
- WB: reg_write=1; wb_sel=1 for LOAD, else 0; retire; -> FETCH.
- HALT: halted=1. start=1 -> FETCH (resume). retired is preserved.
- Handshake rules:
  - mem_req and mem_we stay constant from assertion until the mem_ready cycle inclusive.
  - At most one access is outstanding.
  - mem_ready with mem_req=0 has no effect.
- retired saturates at 2^CNT_W-1 and never wraps.
- Latency with mem_ready held high, in cycles per instruction: ALU_A/ALU_I 4, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, HALT 2 to reach HALT.

Test Plan:
- Reset, start=1, mem_ready=1, opcode=0 -> states 1,2,3,5,1; reg_write=1, wb_sel=0 only in WB; retired=1 after 4 cycles.
- opcode=2 with mem_ready low for 3 cycles in MEM -> mem_req=1, mem_we=0 held for 4 cycles; then WB with wb_sel=1; retired increments once.
- opcode=4 with alu_zero=0, then opcode=4 with alu_zero=1 -> pc_write=0 then 1 in EXEC, pc_src=1; each takes 3 cycles.
- opcode=6 -> in EXEC: pc_src=3, pc_write=1, reg_write=1, wb_sel=2, alu_src=1.
- opcode=7 -> halted=1, busy=0, retired+1. start=1 -> FETCH; retired unchanged.
- reset pulse in MEM of a STORE -> state=0 and mem_req=0 next cycle, retired=0. CNT_W=2 with 5 retirements -> retired=3.
